multicycle_mips: RTL

// - Parametrised multi-cycle successor to the single-cycle MIPS core; same ISA subset: add/sub/and/or/slt, lw, sw, beq, j, jal, jr.
// - Sits between instruction memory and data SRAM; one shared ALU sequenced by an FSM.
// - Both memories use valid/ready handshakes, so multi-cycle SRAM latency stalls the core instead of corrupting it.

---
 rtl/multicycle_mips.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core (add/sub/and/or/slt, lw, sw, beq, j, jal, jr) with one shared ALU
// sequenced by a FETCH/DECODE/EXEC/MEM/WB state machine and handshaked memories.
module multicycle_mips #(
    parameter int          DATA_W   = 32,
    parameter int          DADDR_W  = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        IR_addr,
    output logic               IR_req,
    input  logic [31:0]        IR,
    input  logic               IR_valid,
    output logic               CEN,
    output logic               WEN,
    output logic               OEN,
    output logic [DADDR_W-1:0] A,
    output logic [DATA_W-1:0]  ReadData2,
    input  logic [DATA_W-1:0]  ReadDataMem,
    input  logic               mem_ready,
    output logic [DATA_W-1:0]  RF_writedata,
    output logic               retire
);
    localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [4:0] RA_IDX   = 5'd31;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t            state_r, next_state_s;
    logic [31:0]       pc_r, pc_next_s, ir_r;
    logic [DATA_W-1:0] a_r, b_r, imm_r, alu_out_r, mdr_r;
    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              ir_req_r, cen_r, wen_r, retire_r;
    logic [DATA_W-1:0] rf_wd_r;

    logic [5:0]        opcode_s, funct_s;
    logic [RW-1:0]     rs_s, rt_s, rd_s, ra_s;
    logic              is_rtype_s, is_alu_r_s, is_jr_s, is_lw_s, is_sw_s;
    logic              is_beq_s, is_jump_s, is_jal_s;
    logic [DATA_W-1:0] alu_res_s, rf_wdata_s;
    logic [RW-1:0]     rf_waddr_s;
    logic              rf_we_s, retire_s;

    // Field extraction and instruction classification from the latched instruction
    always_comb begin
        opcode_s   = ir_r[31:26];
        funct_s    = ir_r[5:0];
        rs_s       = ir_r[21 +: RW];
        rt_s       = ir_r[16 +: RW];
        rd_s       = ir_r[11 +: RW];
        ra_s       = RA_IDX[RW-1:0];
        is_rtype_s = (opcode_s == OP_RTYPE);
        is_jr_s    = is_rtype_s && (funct_s == FN_JR);
        is_lw_s    = (opcode_s == OP_LW);
        is_sw_s    = (opcode_s == OP_SW);
        is_beq_s   = (opcode_s == OP_BEQ);
        is_jal_s   = (opcode_s == OP_JAL);
        is_jump_s  = (opcode_s == OP_J) || is_jal_s;
        is_alu_r_s = 1'b0;
        case (funct_s)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: is_alu_r_s = is_rtype_s;
            default:                               is_alu_r_s = 1'b0;
        endcase
    end

    // Shared ALU: register ops for R-type, base+offset for loads/stores
    always_comb begin
        alu_res_s = a_r + imm_r;
        if (is_alu_r_s) begin
            case (funct_s)
                FN_ADD:  alu_res_s = a_r + b_r;
                FN_SUB:  alu_res_s = a_r - b_r;
                FN_AND:  alu_res_s = a_r & b_r;
                FN_OR:   alu_res_s = a_r | b_r;
                FN_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
                default: alu_res_s = a_r + b_r;
            endcase
        end else begin
            alu_res_s = a_r + imm_r;
        end
    end

    // Next-state, PC update, register-file write and retire decisions
    always_comb begin
        next_state_s = state_r;
        pc_next_s    = pc_r;
        rf_we_s      = 1'b0;
        rf_waddr_s   = rd_s;
        rf_wdata_s   = alu_out_r;
        retire_s     = 1'b0;
        case (state_r)
            FETCH: begin
                if (IR_valid) begin
                    next_state_s = DECODE;
                    pc_next_s    = pc_r + 32'd4;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DECODE: next_state_s = EXEC;
            EXEC: begin
                if (is_alu_r_s) begin
                    next_state_s = WB;
                end else if (is_lw_s || is_sw_s) begin
                    next_state_s = MEM;
                end else begin
                    // Control transfers and unknown encodings all finish here
                    retire_s     = 1'b1;
                    next_state_s = FETCH;
                    if (is_beq_s) begin
                        if (a_r == b_r) begin
                            pc_next_s = pc_r + {imm_r[29:0], 2'b00};
                        end else begin
                            pc_next_s = pc_r;
                        end
                    end else if (is_jump_s) begin
                        pc_next_s  = {pc_r[31:28], ir_r[25:0], 2'b00};
                        rf_we_s    = is_jal_s;
                        rf_waddr_s = ra_s;
                        rf_wdata_s = DATA_W'(pc_r);
                    end else if (is_jr_s) begin
                        pc_next_s = a_r[31:0];
                    end else begin
                        pc_next_s = pc_r;
                    end
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (is_sw_s) begin
                        retire_s     = 1'b1;
                        next_state_s = FETCH;
                    end else begin
                        next_state_s = WB;
                    end
                end else begin
                    next_state_s = MEM;
                end
            end
            WB: begin
                rf_we_s      = 1'b1;
                rf_waddr_s   = is_lw_s ? rt_s : rd_s;
                rf_wdata_s   = is_lw_s ? mdr_r : alu_out_r;
                retire_s     = 1'b1;
                next_state_s = FETCH;
            end
            default: next_state_s = FETCH;
        endcase
    end

    // State, PC and registered memory-control / retire outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= FETCH;
            pc_r     <= RESET_PC;
            ir_req_r <= 1'b1;
            cen_r    <= 1'b1;
            wen_r    <= 1'b1;
            retire_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            pc_r     <= pc_next_s;
            ir_req_r <= (next_state_s == FETCH);
            cen_r    <= (next_state_s != MEM);
            wen_r    <= !((next_state_s == MEM) && is_sw_s);
            retire_r <= retire_s;
        end
    end

    // Datapath latches: instruction, operands, immediate, ALU result, load data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_r      <= 32'd0;
            a_r       <= {DATA_W{1'b0}};
            b_r       <= {DATA_W{1'b0}};
            imm_r     <= {DATA_W{1'b0}};
            alu_out_r <= {DATA_W{1'b0}};
            mdr_r     <= {DATA_W{1'b0}};
        end else begin
            if ((state_r == FETCH) && IR_valid) begin
                ir_r <= IR;
            end
            if (state_r == DECODE) begin
                a_r   <= regs_r[rs_s];
                b_r   <= regs_r[rt_s];
                imm_r <= {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
            end
            if (state_r == EXEC) begin
                alu_out_r <= alu_res_s;
            end
            if ((state_r == MEM) && mem_ready && is_lw_s) begin
                mdr_r <= ReadDataMem;
            end
        end
    end

    // Register file; index 0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
            rf_wd_r <= {DATA_W{1'b0}};
        end else if (rf_we_s && (rf_waddr_s != {RW{1'b0}})) begin
            regs_r[rf_waddr_s] <= rf_wdata_s;
            rf_wd_r            <= rf_wdata_s;
        end
    end

    assign IR_addr      = pc_r;
    assign IR_req       = ir_req_r;
    assign CEN          = cen_r;
    assign WEN          = wen_r;
    assign OEN          = 1'b0;
    assign A            = alu_out_r[DADDR_W+1:2];
    assign ReadData2    = b_r;
    assign RF_writedata = rf_wd_r;
    assign retire       = retire_r;

endmodule
